// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// fetch FSM states and default geometry.
package fetch_pkg;

  localparam logic [31:0] NOP           = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'd0;
  localparam logic [31:0] DEF_MEM_WORDS = 32'd32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ifid_register.sv
// Generic instruction pipeline register: instruction word, PC+1 and valid.
// Flush inserts a bubble and wins over hold; hold wins over load.
module ifid_register
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_plus1_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_plus1_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc_plus1_q, pc_plus1_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d    = DATA_W'(NOP);
      pc_plus1_d = '0;
      valid_d    = 1'b0;
    end else if (load_i && !hold_i) begin
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q    <= DATA_W'(NOP);
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection (sequential,
// branch, jump), out-of-range halt FSM and the IF/ID pipeline register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic [31:0] redirect_base,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  pc_plus1, br_target, jmp_target;
  logic         out_of_range;
  logic         ifid_load, ifid_flush, ifid_hold;

  assign pc_plus1     = pc_q + 32'd1;
  assign br_target    = redirect_base + sext16(branch_offset);
  assign jmp_target   = {redirect_base[31:26], jump_target};
  assign out_of_range = (pc_q >= MEM_WORDS);

  // Redirects beat the range check so a branch back into memory can rescue an
  // otherwise out-of-range PC; once halted, only reset leaves HALT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump) begin
          pc_d       = jmp_target;
          ifid_flush = 1'b1;
        end else if (branch_taken) begin
          pc_d       = br_target;
          ifid_flush = 1'b1;
        end else if (out_of_range) begin
          state_d    = ST_HALT;
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold  = 1'b1;
        end else begin
          pc_d       = pc_plus1;
          cnt_d      = cnt_q + 32'd1;
          ifid_load  = 1'b1;
        end
      end
      ST_HALT: begin
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  ifid_register #(.DATA_W(32)) u_ifid (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .hold_i     (ifid_hold),
    .instr_i    (instruction),
    .pc_plus1_i (pc_plus1),
    .instr_o    (ifid_instruction),
    .pc_plus1_o (ifid_pc_plus1),
    .valid_o    (ifid_valid)
  );

  assign pc_out      = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule
